// File: rtl/text_pkg.sv
// Shared definitions for the text console: cell word layout, pipeline constants
// and the glyph table used by the font lookup stage.
package text_pkg;

    localparam int DATA_W   = 14;
    localparam int CHR_LSB  = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 11;
    localparam int GLYPH_W  = 8;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [2:0] bg;
        logic [2:0] fg;
        logic [7:0] chr;
    } cell_t;

    // Row 0 is the top byte; bit 7 of each row is the leftmost pixel.
    function automatic logic [GLYPH_W-1:0] glyph_row(input logic [7:0] code,
                                                     input logic [2:0] row);
        logic [63:0] g;
        int          r;
        case (code)
            8'h41:   g = 64'h183C_6666_7E66_6600;
            8'h42:   g = 64'h7C66_667C_6666_7C00;
            8'h48:   g = 64'h6666_667E_6666_6600;
            8'hDB:   g = 64'hFFFF_FFFF_FFFF_FFFF;
            default: g = 64'h0;
        endcase
        r = int'(row);
        return g[GLYPH_W*(7-r) +: GLYPH_W];
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character RAM: one write port, one registered read port, read-first on
// a same-address collision. Contents are never reset.
module text_ram
    import text_pkg::*;
#(
    parameter int DEPTH = 1200,
    parameter int AW    = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Non-blocking read and write on the same edge gives read-first behaviour.
    always_ff @(posedge clk_i) begin
        if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem[waddr_i] <= wdata_i;
        end
        if (int'(raddr_i) < DEPTH) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_console.sv
// Text-mode renderer: maps the vga_sync pixel stream onto a COLS x ROWS grid of
// zoomed 8x8 glyphs with per-cell colours and a blinking cursor, 3-stage pipeline.
module text_console
    import text_pkg::*;
#(
    parameter int         COLS     = 40,
    parameter int         ROWS     = 30,
    parameter int         ZOOM     = 0,
    parameter int         X0       = 0,
    parameter int         Y0       = 0,
    parameter logic [2:0] BORDER   = 3'b000,
    parameter logic       SYNC_POL = 1'b0,
    parameter int         BLINK_FR = 30,
    parameter int         AW       = (COLS*ROWS > 1) ? $clog2(COLS*ROWS) : 1
) (
    input  logic          px_clk,
    input  logic          rst_n,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          active_in,
    input  logic [9:0]    x_in,
    input  logic [9:0]    y_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [13:0]   wr_data,
    input  logic          cursor_en,
    input  logic [6:0]    cursor_col,
    input  logic [5:0]    cursor_row,
    output logic          hsync,
    output logic          vsync,
    output logic [2:0]    rgb
);

    localparam int         DEPTH    = COLS*ROWS;
    localparam int         FW       = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam logic [2:0] SYNC_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

    // S0 geometry
    logic [9:0]    xr, yr, gx_full, gy_full;
    logic [6:0]    col, row;
    logic          in_win, cur_hit;
    logic [AW-1:0] rd_addr;

    always_comb begin
        xr      = x_in - 10'(X0);
        yr      = y_in - 10'(Y0);
        gx_full = xr >> ZOOM;
        gy_full = yr >> ZOOM;
        col     = gx_full[9:3];
        row     = gy_full[9:3];
        in_win  = (x_in >= 10'(X0)) && (y_in >= 10'(Y0)) &&
                  (int'(col) < COLS) && (int'(row) < ROWS);
        cur_hit = cursor_en && in_win && (cursor_col == col) && ({1'b0, cursor_row} == row);
        rd_addr = in_win ? AW'(int'(row) * COLS + int'(col)) : '0;
    end

    logic [13:0] rd_data;
    cell_t       rd_cell;

    text_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i   (px_clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign rd_cell = cell_t'(rd_data);

    // S1: {hsync, vsync, active} plus window/cursor flags and glyph coordinates
    logic [2:0] s1_sync_q;
    logic       s1_win_q, s1_cur_q;
    logic [2:0] s1_gx_q, s1_gy_q;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sync_q <= SYNC_RST;
            s1_win_q  <= 1'b0;
            s1_cur_q  <= 1'b0;
            s1_gx_q   <= '0;
            s1_gy_q   <= '0;
        end else begin
            s1_sync_q <= {hsync_in, vsync_in, active_in};
            s1_win_q  <= in_win;
            s1_cur_q  <= cur_hit;
            s1_gx_q   <= gx_full[2:0];
            s1_gy_q   <= gy_full[2:0];
        end
    end

    // S2: font lookup
    logic [GLYPH_W-1:0] row_bits;
    logic               glyph_bit;
    logic [2:0]         s2_sync_q;
    logic               s2_win_q, s2_cur_q, s2_bit_q;
    logic [2:0]         s2_fg_q, s2_bg_q;

    always_comb begin
        row_bits  = glyph_row(rd_cell.chr, s1_gy_q);
        glyph_bit = row_bits[3'd7 - s1_gx_q];
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sync_q <= SYNC_RST;
            s2_win_q  <= 1'b0;
            s2_cur_q  <= 1'b0;
            s2_bit_q  <= 1'b0;
            s2_fg_q   <= '0;
            s2_bg_q   <= '0;
        end else begin
            s2_sync_q <= s1_sync_q;
            s2_win_q  <= s1_win_q;
            s2_cur_q  <= s1_cur_q;
            s2_bit_q  <= glyph_bit;
            s2_fg_q   <= rd_cell.fg;
            s2_bg_q   <= rd_cell.bg;
        end
    end

    // Blink: frame counter advances on each vsync assertion edge
    logic          vs_prev_q, frame_edge, blink_q, blink_d;
    logic [FW-1:0] frame_q, frame_d;

    always_comb begin
        frame_edge = (vsync_in == SYNC_POL) && (vs_prev_q != SYNC_POL);
        frame_d    = frame_q;
        blink_d    = blink_q;
        if (frame_edge) begin
            if (frame_q == FW'(BLINK_FR - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= ~SYNC_POL;
            frame_q   <= '0;
            blink_q   <= 1'b0;
        end else begin
            vs_prev_q <= vsync_in;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
        end
    end

    // S3: colour select
    logic       swap;
    logic [2:0] fg_sel, bg_sel, rgb_d, rgb_q;
    logic       hs_q, vs_q;

    always_comb begin
        swap   = s2_cur_q && blink_q;
        fg_sel = swap ? s2_bg_q : s2_fg_q;
        bg_sel = swap ? s2_fg_q : s2_bg_q;
        if (!s2_sync_q[0]) begin
            rgb_d = 3'b000;
        end else if (!s2_win_q) begin
            rgb_d = BORDER;
        end else begin
            rgb_d = s2_bit_q ? fg_sel : bg_sel;
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= s2_sync_q[2];
            vs_q  <= s2_sync_q[1];
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hs_q;
    assign vsync = vs_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: 4x3 grid, 2x zoom, window origin (16,8),
// magenta border, 2-frame cursor blink.
module tb_text_console;

    localparam int         COLS     = 4;
    localparam int         ROWS     = 3;
    localparam int         ZOOM     = 1;
    localparam int         X0       = 16;
    localparam int         Y0       = 8;
    localparam logic [2:0] BORDER   = 3'b101;
    localparam int         BLINK_FR = 2;
    localparam int         AW       = 4;
    localparam int         NCELL    = COLS * ROWS;

    logic          px_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hsync_in = 1'b1, vsync_in = 1'b1, active_in = 1'b0;
    logic [9:0]    x_in = '0, y_in = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [13:0]   wr_data = '0;
    logic          cursor_en = 1'b0;
    logic [6:0]    cursor_col = '0;
    logic [5:0]    cursor_row = '0;
    logic          hsync, vsync;
    logic [2:0]    rgb;

    int          n_vec = 0;
    int          n_err = 0;
    logic [13:0] model [NCELL];
    logic [2:0]  exp_q[$];
    logic        exp_hs_q[$];

    text_console #(
        .COLS(COLS), .ROWS(ROWS), .ZOOM(ZOOM), .X0(X0), .Y0(Y0),
        .BORDER(BORDER), .SYNC_POL(1'b0), .BLINK_FR(BLINK_FR)
    ) dut (
        .px_clk(px_clk), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
        .x_in(x_in), .y_in(y_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 px_clk = ~px_clk;

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic probe(input int x, input int y, input logic act, output logic [2:0] got);
        x_in = 10'(x);
        y_in = 10'(y);
        active_in = act;
        repeat (3) tick();
        got = rgb;
    endtask

    task automatic write_cell(input int a, input logic [13:0] d);
        wr_en = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic frame_pulse();
        vsync_in = 1'b0;
        tick();
        vsync_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        active_in = 1'b1;
        x_in = 10'd20;
        y_in = 10'd8;
        repeat (4) tick();
        n_vec++; if (hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
        n_vec++; if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
        n_vec++; if (rgb !== 3'b000) begin n_err++; $display("FAIL reset_rgb: got %0h expected 0", rgb); end
        vsync_in = 1'b1;
        active_in = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++; if (hsync !== 1'b1) begin n_err++; $display("FAIL release_hs_lat2: got %b expected 1", hsync); end
        n_vec++; if (rgb !== 3'b000) begin n_err++; $display("FAIL release_rgb_lat2: got %0h expected 0", rgb); end
        tick();
        n_vec++; if (hsync !== 1'b0) begin n_err++; $display("FAIL release_hs_lat3: got %b expected 0", hsync); end
        hsync_in = 1'b1;
        repeat (3) tick();
        n_vec++; if (hsync !== 1'b1) begin n_err++; $display("FAIL release_hs_back: got %b expected 1", hsync); end
    endtask

    task automatic fill_ram();
        logic [2:0] bg;
        logic [7:0] code;
        for (int i = 0; i < NCELL; i++) begin
            bg = 3'((i + 1) % 8);
            code = (i % 3 == 0) ? 8'h41 : ((i % 3 == 1) ? 8'h42 : 8'h48);
            model[i] = {bg, ~bg, code};
            write_cell(i, model[i]);
        end
    endtask

    // Glyph row 0 of 'A' is 8'h18; each glyph pixel spans two screen pixels.
    task automatic test_latency();
        logic [7:0] a_row0;
        logic [2:0] e;
        logic       eh;
        a_row0 = 8'h18;
        for (int i = 0; i < 16; i++) begin
            x_in = 10'(X0 + i);
            y_in = 10'(Y0);
            active_in = 1'b1;
            hsync_in = (i == 5) ? 1'b0 : 1'b1;
            exp_q.push_back(a_row0[7 - (i >> 1)] ? 3'b110 : 3'b001);
            exp_hs_q.push_back(hsync_in);
            tick();
            if (i >= 2) begin
                e = exp_q.pop_front();
                eh = exp_hs_q.pop_front();
                n_vec++; if (rgb !== e) begin n_err++; $display("FAIL latency_rgb px%0d: got %0h expected %0h", i - 2, rgb, e); end
                n_vec++; if (hsync !== eh) begin n_err++; $display("FAIL latency_hs px%0d: got %b expected %b", i - 2, hsync, eh); end
            end
        end
        active_in = 1'b0;
        hsync_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            e = exp_q.pop_front();
            eh = exp_hs_q.pop_front();
            n_vec++; if (rgb !== e) begin n_err++; $display("FAIL latency_rgb tail%0d: got %0h expected %0h", k, rgb, e); end
            n_vec++; if (hsync !== eh) begin n_err++; $display("FAIL latency_hs tail%0d: got %b expected %b", k, hsync, eh); end
        end
    endtask

    task automatic test_geometry();
        int         xs [10] = '{15, 80, 16, 16, 16, 22, 23, 21, 31, 79};
        int         ys [10] = '{ 8,  8,  7, 56,  8,  8,  9,  9, 23, 55};
        logic       acts [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        logic [2:0] exps [10] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b000,
                                  3'b110, 3'b110, 3'b001, 3'b001, 3'b100};
        logic [2:0] got;
        for (int i = 0; i < 10; i++) begin
            probe(xs[i], ys[i], acts[i], got);
            n_vec++;
            if (got !== exps[i]) begin
                n_err++;
                $display("FAIL geometry (%0d,%0d): got %0h expected %0h", xs[i], ys[i], got, exps[i]);
            end
        end
    endtask

    // Cell 5 holds 'H' (bg 6, fg 1); pixel (38,24) is glyph (3,0): 'H' off, 'B' on.
    task automatic test_collision();
        logic [2:0] got;
        x_in = 10'd38;
        y_in = 10'd24;
        active_in = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd5;
        wr_data = {3'd6, 3'd1, 8'h42};
        tick();
        wr_en = 1'b0;
        active_in = 1'b0;
        tick();
        tick();
        n_vec++; if (rgb !== 3'd6) begin n_err++; $display("FAIL collision_old: got %0h expected 6", rgb); end
        model[5] = {3'd6, 3'd1, 8'h42};
        probe(38, 24, 1'b1, got);
        n_vec++; if (got !== 3'd1) begin n_err++; $display("FAIL collision_new: got %0h expected 1", got); end
    endtask

    // Glyph (7,7) is off and glyph (2,1) is on for every glyph in use.
    task automatic test_out_of_range();
        logic [2:0] got;
        int         bx, by;
        write_cell(NCELL, 14'h3FFF);
        write_cell(15, 14'h0000);
        for (int i = 0; i < NCELL; i++) begin
            bx = X0 + (i % COLS) * 16;
            by = Y0 + (i / COLS) * 16;
            probe(bx + 14, by + 14, 1'b1, got);
            n_vec++; if (got !== model[i][13:11]) begin n_err++; $display("FAIL readback_bg cell%0d: got %0h expected %0h", i, got, model[i][13:11]); end
            probe(bx + 4, by + 2, 1'b1, got);
            n_vec++; if (got !== model[i][10:8]) begin n_err++; $display("FAIL readback_fg cell%0d: got %0h expected %0h", i, got, model[i][10:8]); end
        end
    endtask

    // Cursor on cell 6 (bg 7, fg 0); probe its background pixel across six frames.
    task automatic test_cursor();
        logic [2:0] got, e;
        cursor_en = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 6'd1;
        for (int f = 0; f < 6; f++) begin
            if (f > 0) frame_pulse();
            probe(62, 38, 1'b1, got);
            e = (f == 2 || f == 3) ? 3'd0 : 3'd7;
            n_vec++; if (got !== e) begin n_err++; $display("FAIL cursor frame%0d: got %0h expected %0h", f, got, e); end
            if (f == 3) begin
                probe(62, 38, 1'b0, got);
                n_vec++; if (got !== 3'd0) begin n_err++; $display("FAIL cursor_inactive: got %0h expected 0", got); end
                probe(68, 26, 1'b1, got);
                n_vec++; if (got !== 3'd7) begin n_err++; $display("FAIL cursor_neighbour: got %0h expected 7", got); end
                cursor_col = 7'd4;
                probe(62, 38, 1'b1, got);
                n_vec++; if (got !== 3'd7) begin n_err++; $display("FAIL cursor_off_grid: got %0h expected 7", got); end
                cursor_col = 7'd2;
                cursor_en = 1'b0;
                probe(62, 38, 1'b1, got);
                n_vec++; if (got !== 3'd7) begin n_err++; $display("FAIL cursor_disabled: got %0h expected 7", got); end
                cursor_en = 1'b1;
            end
        end
        cursor_en = 1'b0;
    endtask

    initial begin
        test_reset();
        fill_ram();
        test_latency();
        test_geometry();
        test_collision();
        test_out_of_range();
        test_cursor();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
